// File: rtl/lvds_video_timing_ctrl.sv
// ---------------------------------------------------------------------------
// lvds_video_timing_ctrl
//   Raster timing generator and pixel pump for the LVDS transmitter. It runs
//   entirely in the DotClock domain. It starts and stops only on frame
//   boundaries, so the panel never sees a partial frame.
//
// Ports
//   clk           DotClock; all logic runs on the rising edge
//   rst           asynchronous reset, active low
//   enable        level request to run video
//   pix_valid     upstream pixel available
//   pix_data      {R,G,B} from the upstream frame source
//   pix_ready     combinational; the pixel is consumed this cycle when valid
//   HSync/VSync   sync outputs to the transmitter, polarity set by *_POL
//   DataEnable    high for active pixels
//   Red/Green/Blue  registered pixel colour (0 in blanking and on underflow)
//   frame_start   one-cycle pulse on the first DataEnable of each frame
//   underflow     sticky flag: an active slot arrived with no valid pixel
//   underflow_clr clears underflow; a new miss in the same cycle wins
//   busy          controller is not idle
// ---------------------------------------------------------------------------
module lvds_video_timing_ctrl #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 21,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        pix_valid,
    input  logic [23:0] pix_data,
    output logic        pix_ready,
    output logic        HSync,
    output logic        VSync,
    output logic        DataEnable,
    output logic [7:0]  Red,
    output logic [7:0]  Green,
    output logic [7:0]  Blue,
    output logic        frame_start,
    output logic        underflow,
    input  logic        underflow_clr,
    output logic        busy
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    // The zone bounds use one extra bit, because the sync end can equal the
    // total when the back porch is zero.
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW:0]   H_ACT_E  = (HW+1)'(H_ACTIVE);
    localparam logic [VW:0]   V_ACT_E  = (VW+1)'(V_ACTIVE);
    localparam logic [HW:0]   HS_BEG   = (HW+1)'(H_ACTIVE + H_FP);
    localparam logic [HW:0]   HS_END   = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW:0]   VS_BEG   = (VW+1)'(V_ACTIVE + V_FP);
    localparam logic [VW:0]   VS_END   = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    state_t        state_q, state_d;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          running;
    logic          frame_end;
    logic          active;
    logic          hs_zone;
    logic          vs_zone;
    rgb_t          rgb_q;

    assign running   = (state_q != IDLE);
    assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    assign active    = running && ({1'b0, h_cnt} < H_ACT_E) && ({1'b0, v_cnt} < V_ACT_E);
    assign hs_zone   = ({1'b0, h_cnt} >= HS_BEG) && ({1'b0, h_cnt} < HS_END);
    assign vs_zone   = ({1'b0, v_cnt} >= VS_BEG) && ({1'b0, v_cnt} < VS_END);

    assign pix_ready = active;
    assign busy      = running;
    assign Red       = rgb_q.r;
    assign Green     = rgb_q.g;
    assign Blue      = rgb_q.b;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (enable) state_d = RUN;
            RUN:       if (!enable) state_d = STOP_PEND;
            // Re-enabling only clears the pending stop. The counters keep
            // running, so the raster is not disturbed.
            STOP_PEND: begin
                if (enable)         state_d = RUN;
                else if (frame_end) state_d = IDLE;
            end
            default:   state_d = IDLE;
        endcase
    end

    // ---------------- raster counters ----------------
    // The counters are held at the origin while idle, so the first running
    // cycle is pixel (0,0).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!running) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // ---------------- registered outputs (one-clock latency) ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            HSync       <= ~HS_POL;
            VSync       <= ~VS_POL;
            DataEnable  <= 1'b0;
            rgb_q       <= '0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            HSync       <= (running && hs_zone) ? HS_POL : ~HS_POL;
            VSync       <= (running && vs_zone) ? VS_POL : ~VS_POL;
            DataEnable  <= active;
            rgb_q       <= (active && pix_valid) ? rgb_t'(pix_data) : '0;
            frame_start <= running && (h_cnt == '0) && (v_cnt == '0);
            // A fresh miss takes priority over a clear in the same cycle.
            if (active && !pix_valid) underflow <= 1'b1;
            else if (underflow_clr)   underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lvds_video_timing_ctrl.sv
module tb_lvds_video_timing_ctrl;

    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 2, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;   // 8
    localparam int VT = VA + VF + VS + VB;   // 5
    localparam int FT = HT * VT;             // 40
    localparam bit HPOL = 1'b0, VPOL = 1'b0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        pix_valid = 1'b0;
    logic [23:0] pix_data = 24'h000001;
    logic        underflow_clr = 1'b0;
    logic        pix_ready, HSync, VSync, DataEnable, frame_start, underflow, busy;
    logic [7:0]  Red, Green, Blue;
    bit          rnd_data = 1'b0;
    bit          chk_on = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lvds_video_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(HPOL), .VS_POL(VPOL)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_ready(pix_ready), .HSync(HSync),
        .VSync(VSync), .DataEnable(DataEnable), .Red(Red), .Green(Green),
        .Blue(Blue), .frame_start(frame_start), .underflow(underflow),
        .underflow_clr(underflow_clr), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Upstream source: counting pixels, or random data in the soak phase.
    always @(posedge clk) begin
        if (rnd_data)                         pix_data <= 24'($urandom);
        else if (rst && pix_ready && pix_valid) pix_data <= pix_data + 24'd1;
    end

    // ---------------- reference model ----------------
    // The frame is a single position m_t in 0..FT-1. The line is m_t/HT and
    // the pixel is m_t%HT.
    bit          m_run, m_stop;
    int          m_t;
    logic        e_de, e_hs, e_vs, e_fs, e_uf;
    logic [23:0] e_rgb;

    function automatic bit m_act();
        return m_run && (m_t % HT) < HA && (m_t / HT) < VA;
    endfunction
    function automatic bit m_hzone();
        return m_run && (m_t % HT) >= HA + HF && (m_t % HT) < HA + HF + HS;
    endfunction
    function automatic bit m_vzone();
        return m_run && (m_t / HT) >= VA + VF && (m_t / HT) < VA + VF + VS;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_run <= 0; m_stop <= 0; m_t <= 0;
            e_de <= 0; e_hs <= ~HPOL; e_vs <= ~VPOL; e_fs <= 0; e_uf <= 0; e_rgb <= '0;
        end else begin
            e_de  <= m_act();
            e_hs  <= m_hzone() ? HPOL : ~HPOL;
            e_vs  <= m_vzone() ? VPOL : ~VPOL;
            e_rgb <= (m_act() && pix_valid) ? pix_data : 24'h0;
            e_fs  <= m_run && m_t == 0;
            if (m_act() && !pix_valid) e_uf <= 1'b1;
            else if (underflow_clr)    e_uf <= 1'b0;
            if (!m_run) begin
                m_run <= enable; m_t <= 0; m_stop <= 0;
            end else begin
                m_t <= (m_t + 1) % FT;
                // Stop only at the frame end, and only if the request was
                // already standing and is still present.
                if (m_t == FT - 1 && m_stop && !enable) begin
                    m_run <= 0; m_stop <= 0;
                end else begin
                    m_stop <= !enable;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("de", DataEnable, e_de);
            chk("hsync", HSync, e_hs);
            chk("vsync", VSync, e_vs);
            chk("rgb", {Red, Green, Blue}, e_rgb);
            chk("frame_start", frame_start, e_fs);
            chk("underflow", underflow, e_uf);
            chk("pix_ready", pix_ready, m_act());
            chk("busy", busy, m_run);
        end
    end

    task automatic wait_fs(output int n, input int lim);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < lim);
        chk("fs_seen", frame_start, 1);
    endtask

    initial begin
        int n, de, hl, vl, hbad, vbad, dbad, fss;
        bit b38;
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, de, hl, vl, hbad, vbad, dbad, fss;
        bit b38;
        chk_on = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;

        // Idle with enable low.
        repeat (50) @(negedge clk);
        chk("idle_hs", HSync, 1);
        chk("idle_vs", VSync, 1);
        chk("idle_de", DataEnable, 0);
        chk("idle_busy", busy, 0);
        chk("idle_ready", pix_ready, 0);

        // Nominal timing.
        #1 enable = 1'b1; pix_valid = 1'b1;
        wait_fs(n, 100);
        chk("start_latency", n, 2);
        chk("first_rgb", {Red, Green, Blue}, 24'h000001);
        chk("first_de", DataEnable, 1);
        de = 0; hl = 0; vl = 0; hbad = 0; vbad = 0; dbad = 0;
        for (int i = 0; i < FT; i++) begin
            de += int'(DataEnable);
            hl += int'(!HSync);
            vl += int'(!VSync);
            if (HSync !== !((i % 8) == 5 || (i % 8) == 6)) hbad++;
            if (VSync !== !((i / 8) == 3)) vbad++;
            if (DataEnable !== ((i % 8) < 4 && (i / 8) < 2)) dbad++;
            @(negedge clk);
        end
        chk("fs_period", frame_start, 1);
        chk("de_count", de, 8);
        chk("hs_low_count", hl, 10);
        chk("vs_low_count", vl, 8);
        chk("hs_shape", hbad, 0);
        chk("vs_shape", vbad, 0);
        chk("de_shape", dbad, 0);

        // Graceful stop at clock 10 of the frame.
        de = 0; fss = 0; b38 = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 10) enable = 1'b0;
            if (i == 38) b38 = busy;
            de += int'(DataEnable);
            if (i > 0 && frame_start) fss++;
            @(negedge clk);
        end
        chk("stop_de_count", de, 8);
        chk("stop_no_fs", fss, 0);
        chk("stop_busy_late", b38, 1);
        chk("stop_idle", busy, 0);

        // Re-enable while the stop is pending.
        enable = 1'b1;
        wait_fs(n, 100);
        chk("restart_latency", n, 2);
        for (int i = 0; i < FT; i++) begin
            if (i == 10) enable = 1'b0;
            if (i == 20) enable = 1'b1;
            @(negedge clk);
        end
        chk("reenable_period", frame_start, 1);
        chk("reenable_busy", busy, 1);

        // Underflow on the third active slot.
        chk("uf_before", underflow, 0);
        @(posedge clk); #1 pix_valid = 1'b0;
        @(posedge clk); #1 pix_valid = 1'b1;
        @(negedge clk);
        chk("uf_de", DataEnable, 1);
        chk("uf_rgb", {Red, Green, Blue}, 24'h0);
        chk("uf_set", underflow, 1);
        repeat (5) @(negedge clk);
        chk("uf_sticky", underflow, 1);
        underflow_clr = 1'b1;
        @(negedge clk);
        underflow_clr = 1'b0;
        chk("uf_cleared", underflow, 0);
        n = 0;
        while (!pix_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("uf_slot_found", pix_ready, 1);
        pix_valid = 1'b0; underflow_clr = 1'b1;
        @(negedge clk);
        pix_valid = 1'b1; underflow_clr = 1'b0;
        chk("uf_set_wins", underflow, 1);

        // Asynchronous reset in the middle of a frame.
        wait_fs(n, 100);
        repeat (16) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_de", DataEnable, 0);
        chk("arst_hs", HSync, 1);
        chk("arst_vs", VSync, 1);
        chk("arst_rgb", {Red, Green, Blue}, 24'h0);
        chk("arst_fs", frame_start, 0);
        chk("arst_uf", underflow, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", pix_ready, 0);
        @(negedge clk);
        #1 rst = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 20);
        chk("arst_restart", n, 2);

        // Random soak.
        rnd_data = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 99) < 3) enable = !enable;
            pix_valid     = ($urandom_range(0, 99) < 85);
            underflow_clr = ($urandom_range(0, 99) < 5);
        end
        @(negedge clk);
        chk_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
